// File: rtl/findmax_pkg.sv
// Shared types and default sizing for the find-max arbiter and its datapath.
package findmax_pkg;

    localparam int NUM_REQ_D = 4;
    localparam int DATA_W_D  = 8;
    localparam int CNT_W_D   = 8;
    localparam int TIMEOUT_D = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [$clog2(NUM_REQ_D)-1:0] id;
        logic [DATA_W_D-1:0]          max_val;
        logic [CNT_W_D-1:0]           count;
        logic                         err;
    } result_t;

endpackage

// File: rtl/findmax_max_track.sv
// Running-maximum and saturating sample counter for one session at a time.
module max_track
    import findmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] upd_max,
    output logic [CNT_W-1:0]  upd_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [DATA_W-1:0] max_val;
    logic [CNT_W-1:0]  count;
    logic              first;

    // upd_* include the sample on the current cycle so a closing sample can be reported at once
    always_comb begin
        upd_max   = max_val;
        upd_count = count;
        if (sample_valid) begin
            if (first || (data > max_val)) begin
                upd_max = data;
            end
            if (count != CNT_SAT) begin
                upd_count = count + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_val <= '0;
            count   <= '0;
            first   <= 1'b1;
        end else if (sample_valid) begin
            max_val <= upd_max;
            count   <= upd_count;
            first   <= 1'b0;
        end
    end

endmodule

// File: rtl/findmax_arbiter.sv
// Round-robin arbiter sharing one running-maximum engine between NUM_REQ streams,
// reporting max, sample count and requester id as a one-cycle result pulse.
module findmax_arbiter
    import findmax_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int CNT_W   = CNT_W_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ-1:0]        in_last,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [DATA_W-1:0]         res_max,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [ID_W:0]    NUM_REQ_L  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_IDX   = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TIMER_ONE  = TMR_W'(1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [TMR_W-1:0]   timer;

    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_found;
    logic [ID_W:0]      cand;

    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;

    logic               accept;
    logic               clear;
    logic [DATA_W-1:0]  upd_max;
    logic [CNT_W-1:0]   upd_count;

    // Search upward from ptr with wrap; the first requesting index wins
    always_comb begin
        pick_idx    = '0;
        pick_found  = 1'b0;
        pick_onehot = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= NUM_REQ_L) begin
                cand = cand - NUM_REQ_L;
            end
            if (!pick_found && req[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = (state == RUN) && sel_valid;
    assign clear  = (state == IDLE) && pick_found;
    assign busy   = (state != IDLE);

    max_track #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_max_track (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .sample_valid (accept),
        .data         (sel_data),
        .upd_max      (upd_max),
        .upd_count    (upd_count)
    );

    // Results latch on the edge that enters DONE, so res_valid and its fields appear together
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            ptr       <= '0;
            timer     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_max   <= '0;
            res_count <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt     <= pick_onehot;
                        gnt_idx <= pick_idx;
                        timer   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if ((accept && sel_last) || (!accept && (timer == TIMER_LAST))) begin
                        state     <= DONE;
                        gnt       <= '0;
                        res_valid <= 1'b1;
                        res_id    <= gnt_idx;
                        res_max   <= upd_max;
                        res_count <= upd_count;
                        res_err   <= !accept;
                        ptr       <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                        timer     <= '0;
                    end else if (accept) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
